// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: arbitrates WB and multi-cycle writes to the register file and tracks outstanding multi-cycle destinations
module rf_write_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  output logic        a_ready,
  input  logic        b_valid,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  output logic        b_ready,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic [5:0]  busy_cnt,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
  output logic        sb_err
);
  localparam int WW = ($clog2(STARVE_LIMIT + 1) < 2) ? 2 : $clog2(STARVE_LIMIT + 1);
  logic [WW-1:0] wait_q, wait_d;
  logic [31:0] busy_q, busy_d, set_v, clr_v;
  logic [5:0]  busy_cnt_q, busy_cnt_d;
  logic        rf_we_q, rf_we_d, sb_err_q, sb_err_d;
  logic [4:0]  rf_rd_q, rf_rd_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;
  logic        lim, a_acc, b_acc;
  assign lim      = wait_q == WW'(STARVE_LIMIT);
  assign a_ready  = !(b_valid && lim);
  assign b_ready  = !a_valid || lim;
  assign a_acc    = a_valid && a_ready;
  assign b_acc    = b_valid && b_ready;
  assign rs1_busy = busy_q[rs1_addr];
  assign rs2_busy = busy_q[rs2_addr];
  assign busy_cnt = busy_cnt_q;
  assign rf_we    = rf_we_q;
  assign rf_rd    = rf_rd_q;
  assign rf_wdata = rf_wdata_q;
  assign sb_err   = sb_err_q;
  // next state: starvation counter, scoreboard (set beats clear), write port, sticky error
  always_comb begin
    wait_d     = (b_valid && !b_acc) ? (lim ? wait_q : wait_q + WW'(1)) : '0;
    set_v      = (iss_valid && iss_rd != 5'd0) ? 32'(1) << iss_rd : '0;
    clr_v      = b_acc ? 32'(1) << b_rd : '0;
    busy_d     = ((busy_q & ~clr_v) | set_v) & ~32'd1;
    busy_cnt_d = '0;
    for (int i = 1; i < 32; i++) busy_cnt_d = busy_cnt_d + 6'(busy_d[i]);
    rf_we_d    = a_acc ? a_rd != 5'd0 : b_acc && b_rd != 5'd0;
    rf_rd_d    = a_acc ? a_rd : b_acc ? b_rd : rf_rd_q;
    rf_wdata_d = a_acc ? a_data : b_acc ? b_data : rf_wdata_q;
    sb_err_d   = sb_err_q
               | (b_acc && b_rd != 5'd0 && !busy_q[b_rd])
               | (iss_valid && iss_rd != 5'd0 && busy_q[iss_rd])
               | (a_acc && a_rd != 5'd0 && busy_q[a_rd]);
  end
  // state registers; reset discards any request presented in the same cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_q     <= '0;
      busy_q     <= '0;
      busy_cnt_q <= '0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= '0;
      rf_wdata_q <= '0;
      sb_err_q   <= 1'b0;
    end else begin
      wait_q     <= wait_d;
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
      sb_err_q   <= sb_err_d;
    end
  end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed vectors with a write-port scoreboard
module tb_rf_write_arbiter;
  logic clk = 1'b0, rst = 1'b0;
  logic a_valid = 1'b0, b_valid = 1'b0, iss_valid = 1'b0;
  logic [4:0] a_rd = '0, b_rd = '0, iss_rd = '0, rs1_addr = '0, rs2_addr = '0;
  logic [31:0] a_data = '0, b_data = '0;
  logic a_ready, b_ready, rs1_busy, rs2_busy, rf_we, sb_err;
  logic [5:0] busy_cnt;
  logic [4:0] rf_rd;
  logic [31:0] rf_wdata;
  int total = 0, bad = 0;
  logic [36:0] exp_q[$];
  always #5 clk = ~clk;
  rf_write_arbiter #(.STARVE_LIMIT(3)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .iss_valid(iss_valid), .iss_rd(iss_rd),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .busy_cnt(busy_cnt), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata), .sb_err(sb_err)
  );
  task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // one cycle of stimulus: drive, check readiness, queue expected write, advance past the edge
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                      input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                      input logic iv, input logic [4:0] ird, input logic ear, input logic ebr);
    a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd;
    iss_valid = iv; iss_rd = ird;
    #1;
    chk("a_ready", 37'(a_ready), 37'(ear));
    chk("b_ready", 37'(b_ready), 37'(ebr));
    if (rst && av && ear && ard != 5'd0) exp_q.push_back({ard, ad});
    if (rst && bv && ebr && brd != 5'd0) exp_q.push_back({brd, bd});
    @(posedge clk);
    #1;
  endtask
  task automatic idle();
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b1);
  endtask
  // monitor: every write seen on the port must match the oldest queued expectation
  initial forever begin
    @(negedge clk);
    if (rf_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_write: got rd=%0d data=%0h expected none", rf_rd, rf_wdata);
      end else chk("rf_write", {rf_rd, rf_wdata}, exp_q.pop_front());
    end
  end
  initial begin
    @(posedge clk); #1;
    step(1'b1, 5'd8, 32'h11, 1'b0, 5'd0, 32'd0, 1'b1, 5'd8, 1'b1, 1'b0);
    chk("rst_rf_we", 37'(rf_we), 37'd0);
    chk("rst_busy_cnt", 37'(busy_cnt), 37'd0);
    chk("rst_sb_err", 37'(sb_err), 37'd0);
    rst = 1'b1;
    step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    chk("single_a_we", 37'(rf_we), 37'd1);
    idle();
    chk("idle_we", 37'(rf_we), 37'd0);
    chk("idle_hold", {rf_rd, rf_wdata}, {5'd5, 32'hDEADBEEF});
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd20, 1'b1, 1'b1);
    step(1'b1, 5'd1, 32'hA0, 1'b1, 5'd20, 32'hBBBB0000, 1'b0, 5'd0, 1'b1, 1'b0);
    step(1'b1, 5'd2, 32'hA1, 1'b1, 5'd20, 32'hBBBB0000, 1'b0, 5'd0, 1'b1, 1'b0);
    step(1'b1, 5'd3, 32'hA2, 1'b1, 5'd20, 32'hBBBB0000, 1'b0, 5'd0, 1'b1, 1'b0);
    step(1'b1, 5'd1, 32'hA3, 1'b1, 5'd20, 32'hBBBB0000, 1'b0, 5'd0, 1'b0, 1'b1);
    step(1'b1, 5'd2, 32'hA4, 1'b1, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    chk("starve_sb_err", 37'(sb_err), 37'd0);
    chk("starve_cnt", 37'(busy_cnt), 37'd0);
    rs1_addr = 5'd7;
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 1'b1, 1'b1);
    chk("sb_rs1_busy", 37'(rs1_busy), 37'd1);
    chk("sb_cnt1", 37'(busy_cnt), 37'd1);
    chk("rs2_x0", 37'(rs2_busy), 37'd0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 1'b1, 5'd0, 1'b1, 1'b1);
    chk("sb_rs1_clear", 37'(rs1_busy), 37'd0);
    chk("sb_cnt0", 37'(busy_cnt), 37'd0);
    chk("sb_no_err", 37'(sb_err), 37'd0);
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b1, 1'b1);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b1, 5'd10, 1'b1, 1'b1);
    chk("swap_cnt", 37'(busy_cnt), 37'd1);
    chk("swap_err", 37'(sb_err), 37'd0);
    rs1_addr = 5'd10;
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd10, 32'h1010, 1'b1, 5'd10, 1'b1, 1'b1);
    chk("same_edge_busy", 37'(rs1_busy), 37'd1);
    chk("same_edge_cnt", 37'(busy_cnt), 37'd1);
    chk("same_edge_err", 37'(sb_err), 37'd1);
    rst = 1'b0;
    idle();
    rst = 1'b1;
    chk("rst2_err", 37'(sb_err), 37'd0);
    chk("rst2_cnt", 37'(busy_cnt), 37'd0);
    step(1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    chk("x0_we", 37'(rf_we), 37'd0);
    step(1'b0, 5'd0, 32'd0, 1'b1, 5'd12, 32'hC0FFEE, 1'b0, 5'd0, 1'b1, 1'b1);
    chk("b_err_we", 37'(rf_we), 37'd1);
    chk("b_err", 37'(sb_err), 37'd1);
    idle();
    idle();
    chk("err_sticky", 37'(sb_err), 37'd1);
    rst = 1'b0;
    idle();
    rst = 1'b1;
    rs1_addr = 5'd3;
    step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b1, 1'b1);
    step(1'b1, 5'd3, 32'h3333, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    chk("waw_err", 37'(sb_err), 37'd1);
    chk("waw_busy", 37'(rs1_busy), 37'd1);
    rst = 1'b0;
    step(1'b1, 5'd6, 32'h6666, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    chk("midrst_we", 37'(rf_we), 37'd0);
    chk("midrst_cnt", 37'(busy_cnt), 37'd0);
    chk("midrst_busy", 37'(rs1_busy), 37'd0);
    chk("midrst_err", 37'(sb_err), 37'd0);
    rst = 1'b1;
    idle();
    idle();
    chk("queue_drained", 37'(exp_q.size()), 37'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
